// File: rtl/tlb_miss_arbiter.sv
// tlb_miss_arbiter: shares one page-table walker between ITLB and DTLB misses, D-first with I anti-starvation.
// Define RAFI_TLB_ARB_SATP_FLUSH_EN to discard and re-walk results made stale by a satp write.
package tlb_miss_arbiter_pkg;
   typedef enum logic [1:0] {
      MemoryAccessType_Instruction = 2'd0,
      MemoryAccessType_Load        = 2'd1,
      MemoryAccessType_Store       = 2'd2
   } MemoryAccessType;
endpackage

module tlb_miss_arbiter
   import tlb_miss_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iMissReq,
   input  logic [19:0]     iMissPage,
   output logic            iMissAck,
   output logic            iTlbWriteEnable,
   input  logic            dMissReq,
   input  logic [19:0]     dMissPage,
   input  MemoryAccessType dMissType,
   output logic            dMissAck,
   output logic            dTlbWriteEnable,
   output logic            walkerEnable,
   output logic [19:0]     walkerPage,
   output MemoryAccessType walkerType,
   input  logic            walkerDone,
   input  logic            walkerTlbWriteEnable,
   input  logic            csrSatpWrite,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WALK} state_t;
   state_t          state, state_n;
   logic            owner_d, owner_d_n;
   logic [19:0]     page_q, page_n;
   MemoryAccessType type_q, type_n;
   logic [3:0]      starve_q, starve_n;
   logic            stale_q, stale_n;
   logic            grant_i, walk, deliver;
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         owner_d  <= 1'b0;
         page_q   <= '0;
         type_q   <= MemoryAccessType_Instruction;
         starve_q <= '0;
         stale_q  <= 1'b0;
      end else begin
         state    <= state_n;
         owner_d  <= owner_d_n;
         page_q   <= page_n;
         type_q   <= type_n;
         starve_q <= starve_n;
         stale_q  <= stale_n;
      end
   // I only overtakes a pending D once D has been granted STARVE_LIMIT times in a row
   always_comb begin
      state_n   = state;
      owner_d_n = owner_d;
      page_n    = page_q;
      type_n    = type_q;
      starve_n  = starve_q;
      grant_i   = iMissReq && (!dMissReq || starve_q == 4'(STARVE_LIMIT));
      if (state == IDLE && (iMissReq || dMissReq)) begin
         state_n   = ISSUE;
         owner_d_n = !grant_i;
         page_n    = grant_i ? iMissPage : dMissPage;
         type_n    = grant_i ? MemoryAccessType_Instruction : dMissType;
         starve_n  = (!grant_i && iMissReq) ? ((starve_q == 4'hf) ? starve_q : starve_q + 4'd1) : 4'd0;
      end
      if (state == ISSUE)
         state_n = WALK;
      if (state == WALK && walkerDone)
         state_n = stale_q ? ISSUE : IDLE;
   end
`ifdef RAFI_TLB_ARB_SATP_FLUSH_EN
   // a satp write landing on the done cycle of a re-walk taints that re-walk too
   always_comb
      stale_n = (state == WALK && walkerDone) ? (stale_q && csrSatpWrite) : (stale_q || (state != IDLE && csrSatpWrite));
`else
   logic unused_satp;
   assign unused_satp = csrSatpWrite;
   assign stale_n = 1'b0;
`endif
   assign walk            = state == WALK && !rst;
   assign deliver         = walk && !stale_q;
   assign busy            = state != IDLE && !rst;
   assign walkerEnable    = state == ISSUE && !rst;
   assign walkerPage      = page_q;
   assign walkerType      = type_q;
   assign iMissAck        = deliver && walkerDone && !owner_d;
   assign dMissAck        = deliver && walkerDone && owner_d;
   assign iTlbWriteEnable = deliver && walkerTlbWriteEnable && !owner_d;
   assign dTlbWriteEnable = deliver && walkerTlbWriteEnable && owner_d;
endmodule

// File: tb/tb_tlb_miss_arbiter.sv
// tb_tlb_miss_arbiter: directed scenarios plus random traffic against a transaction-level model of the arbiter.
module tb_tlb_miss_arbiter;
   import tlb_miss_arbiter_pkg::*;
   localparam int LIMIT = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic iMissReq = 1'b0, dMissReq = 1'b0;
   logic [19:0] iMissPage = '0, dMissPage = '0;
   MemoryAccessType dMissType = MemoryAccessType_Load;
   logic iMissAck, iTlbWriteEnable, dMissAck, dTlbWriteEnable, walkerEnable, busy;
   logic [19:0] walkerPage;
   MemoryAccessType walkerType;
   logic walkerDone = 1'b0, walkerTlbWriteEnable = 1'b0, csrSatpWrite = 1'b0;
   always #5 clk = ~clk;

   tlb_miss_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .iMissReq(iMissReq), .iMissPage(iMissPage), .iMissAck(iMissAck), .iTlbWriteEnable(iTlbWriteEnable),
      .dMissReq(dMissReq), .dMissPage(dMissPage), .dMissType(dMissType), .dMissAck(dMissAck),
      .dTlbWriteEnable(dTlbWriteEnable), .walkerEnable(walkerEnable), .walkerPage(walkerPage),
      .walkerType(walkerType), .walkerDone(walkerDone), .walkerTlbWriteEnable(walkerTlbWriteEnable),
      .csrSatpWrite(csrSatpWrite), .busy(busy)
   );

   int n_tests = 0, n_fail = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // model: walk lifecycle flags, current grant and the consecutive-D-while-I-waits count
   bit m_issue, m_walk, m_stale, m_owner_d;
   logic [19:0] m_page;
   MemoryAccessType m_type;
   int m_starve;
   bit ack_log[$];
   bit auto_mode = 0, i_acked, d_acked;
   int w_cnt = 0;

   task automatic drive();
      if (i_acked || (!iMissReq && $urandom_range(0, 2) == 0)) begin
         iMissReq  = i_acked ? 1'($urandom_range(0, 1)) : 1'b1;
         iMissPage = 20'($urandom);
      end
      if (d_acked || (!dMissReq && $urandom_range(0, 2) == 0)) begin
         dMissReq  = d_acked ? 1'($urandom_range(0, 1)) : 1'b1;
         dMissPage = 20'($urandom);
         dMissType = $urandom_range(0, 1) ? MemoryAccessType_Store : MemoryAccessType_Load;
      end
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
      if (w_cnt > 0) begin
         w_cnt--;
         walkerDone = (w_cnt == 0);
         walkerTlbWriteEnable = (w_cnt == 0) && $urandom_range(0, 1) == 1;
      end else if ($urandom_range(0, 9) == 0) begin
         walkerDone = 1'b1;
         walkerTlbWriteEnable = 1'b1;
      end
      csrSatpWrite = $urandom_range(0, 19) == 0;
   endtask

   task automatic step();
      bit done_ok, n_issue, n_walk, n_stale, grant_d;
      @(negedge clk);
      i_acked = 0;
      d_acked = 0;
      if (iMissAck || dMissAck)
         ack_log.push_back(dMissAck);
      if (rst) begin
         check("rst_we", walkerEnable, 0);
         check("rst_busy", busy, 0);
         check("rst_strobes", {iMissAck, dMissAck, iTlbWriteEnable, dTlbWriteEnable}, 0);
         {m_issue, m_walk, m_stale, m_owner_d} = '0;
         m_page = '0;
         m_type = MemoryAccessType_Instruction;
         m_starve = 0;
         w_cnt = 0;
      end else begin
         done_ok = m_walk && walkerDone && !m_stale;
         check("busy", busy, m_issue || m_walk);
         check("walker_en", walkerEnable, m_issue);
         if (m_issue || m_walk) begin
            check("walker_page", walkerPage, m_page);
            check("walker_type", walkerType, m_type);
         end
         check("i_ack", iMissAck, done_ok && !m_owner_d);
         check("d_ack", dMissAck, done_ok && m_owner_d);
         check("i_twe", iTlbWriteEnable, m_walk && !m_stale && !m_owner_d && walkerTlbWriteEnable);
         check("d_twe", dTlbWriteEnable, m_walk && !m_stale && m_owner_d && walkerTlbWriteEnable);
         i_acked = done_ok && !m_owner_d;
         d_acked = done_ok && m_owner_d;
         if (m_issue)
            w_cnt = $urandom_range(1, 4);
         n_issue = 0;
         n_walk = m_walk || m_issue;
         n_stale = m_stale;
`ifdef RAFI_TLB_ARB_SATP_FLUSH_EN
         if ((m_issue || m_walk) && csrSatpWrite)
            n_stale = 1;
`endif
         if (m_walk && walkerDone) begin
            n_walk = 0;
            n_issue = m_stale;
            n_stale = m_stale && n_stale && csrSatpWrite;
         end
         if (!m_issue && !m_walk && (iMissReq || dMissReq)) begin
            grant_d = dMissReq && !(iMissReq && m_starve == LIMIT);
            m_owner_d = grant_d;
            m_page = grant_d ? dMissPage : iMissPage;
            m_type = grant_d ? dMissType : MemoryAccessType_Instruction;
            m_starve = (grant_d && iMissReq) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            n_issue = 1;
         end
         m_issue = n_issue;
         m_walk = n_walk;
         m_stale = n_stale;
      end
      @(posedge clk);
      #1;
      if (auto_mode)
         drive();
   endtask

   task automatic wait_walk();
      for (int k = 0; k < 8 && !m_walk; k++)
         step();
      if (!m_walk)
         check("walk_timeout", 0, 1);
   endtask

   task automatic run_walk(input int lat, input bit wte);
      wait_walk();
      repeat (lat) step();
      walkerDone = 1'b1;
      walkerTlbWriteEnable = wte;
      step();
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
   endtask

   int n0;
   initial begin
      repeat (2) step();
      rst = 1'b0;
      step();
      check("post_rst_page", walkerPage, 0);
      check("post_rst_type", walkerType, MemoryAccessType_Instruction);
      walkerDone = 1'b1;
      walkerTlbWriteEnable = 1'b1;
      step();
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
      check("spurious_done", ack_log.size(), 0);
      // single D store miss: enable one cycle after the request
      dMissReq = 1'b1;
      dMissPage = 20'h12345;
      dMissType = MemoryAccessType_Store;
      step();
      check("d_latency_en", walkerEnable, 1);
      check("d_latency_page", walkerPage, 20'h12345);
      check("d_latency_type", walkerType, MemoryAccessType_Store);
      run_walk(2, 1);
      dMissReq = 1'b0;
      check("d_single_ack", ack_log.size() == 1 && ack_log[0], 1);
      // simultaneous arrival: D first, I after D's ack
      n0 = ack_log.size();
      iMissReq = 1'b1;
      iMissPage = 20'hABCDE;
      dMissReq = 1'b1;
      dMissPage = 20'h00777;
      dMissType = MemoryAccessType_Load;
      run_walk(1, 1);
      dMissReq = 1'b0;
      run_walk(0, 1);
      iMissReq = 1'b0;
      check("simul_count", ack_log.size() - n0, 2);
      check("simul_first_d", ack_log[n0], 1);
      check("simul_second_i", ack_log[n0 + 1], 0);
      // I held while D streams back-to-back: LIMIT D walks then one I walk
      n0 = ack_log.size();
      iMissReq = 1'b1;
      iMissPage = 20'h0F00D;
      dMissReq = 1'b1;
      for (int w = 0; w <= LIMIT; w++) begin
         dMissPage = 20'(w + 20'h100);
         run_walk(1, 0);
      end
      check("starve_count", ack_log.size() - n0, LIMIT + 1);
      for (int w = 0; w < LIMIT; w++)
         check("starve_d_first", ack_log[n0 + w], 1);
      check("starve_i_last", ack_log[n0 + LIMIT], 0);
      iMissReq = 1'b0;
      dMissReq = 1'b0;
      step();
      // satp write during a walk
      n0 = ack_log.size();
      dMissReq = 1'b1;
      dMissPage = 20'h5A5A5;
      wait_walk();
      csrSatpWrite = 1'b1;
      step();
      csrSatpWrite = 1'b0;
      walkerDone = 1'b1;
      walkerTlbWriteEnable = 1'b1;
      step();
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
`ifdef RAFI_TLB_ARB_SATP_FLUSH_EN
      check("satp_no_ack", ack_log.size() - n0, 0);
      check("satp_reissue", walkerEnable, 1);
      run_walk(1, 1);
`endif
      check("satp_one_ack", ack_log.size() - n0, 1);
      dMissReq = 1'b0;
      step();
      // reset in the middle of a walk
      n0 = ack_log.size();
      dMissReq = 1'b1;
      dMissPage = 20'h33333;
      wait_walk();
      rst = 1'b1;
      walkerDone = 1'b1;
      walkerTlbWriteEnable = 1'b1;
      step();
      rst = 1'b0;
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
      dMissReq = 1'b0;
      check("rst_walk_busy", busy, 0);
      check("rst_walk_no_ack", ack_log.size() - n0, 0);
      iMissReq = 1'b1;
      iMissPage = 20'h44444;
      step();
      check("rst_fresh_en", walkerEnable, 1);
      check("rst_fresh_page", walkerPage, 20'h44444);
      run_walk(1, 1);
      iMissReq = 1'b0;
      check("rst_fresh_ack", ack_log.size() - n0 == 1 && !ack_log[n0], 1);
      step();
      // random traffic
      auto_mode = 1;
      repeat (4000) step();
      auto_mode = 0;
      iMissReq = 1'b0;
      dMissReq = 1'b0;
      csrSatpWrite = 1'b0;
      walkerDone = 1'b0;
      walkerTlbWriteEnable = 1'b0;
      repeat (3) step();
      check("random_acks_seen", ack_log.size() > 100, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
